// File: rtl/chacha_aead_pkg.sv
// Shared types and constants for the Poly1305 block framer.
//   framer_state_t : FSM state encodings
//   blk_t          : 128-bit block payload with byte-keep mask
//   keep_legal     : legal in_keep check (contiguous from bit 0)
//   keep_bytes     : byte count of an in_keep value
package chacha_aead_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned WORD_KEEP_W = 4;
   localparam int unsigned BLK_W       = 128;
   localparam int unsigned BLK_KEEP_W  = 16;
   localparam int unsigned LEN_FIELD_W = 64;
   localparam int unsigned LEN_AAD_LSB = 0;
   localparam int unsigned LEN_PLD_LSB = 64;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AAD  = 3'd1,
      ST_PLD  = 3'd2,
      ST_LEN  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } framer_state_t;

   typedef struct packed {
      logic [BLK_W-1:0]      data;
      logic [BLK_KEEP_W-1:0] keep;
   } blk_t;

   // Only contiguous-from-bit-0 keep patterns are accepted
   function automatic logic keep_legal(input logic [WORD_KEEP_W-1:0] k);
      logic ok;
      ok = 1'b0;
      case (k)
         4'h0, 4'h1, 4'h3, 4'h7, 4'hF: ok = 1'b1;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [2:0] keep_bytes(input logic [WORD_KEEP_W-1:0] k);
      return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
   endfunction

endpackage

// File: rtl/poly1305_word_packer.sv
// Accumulates 32-bit words into a 128-bit little-endian block.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   i_clear      : drop any partial block
//   i_acc        : a legal word is accepted this cycle
//   i_data/i_keep/i_last : the word, its byte enables, segment end
//   o_emit_c     : block completes this cycle (4 words, or last with bytes)
//   o_blk_c      : the completed block, unused bytes zero
module poly1305_word_packer
   import chacha_aead_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic                   i_acc,
   input  logic [WORD_W-1:0]      i_data,
   input  logic [WORD_KEEP_W-1:0] i_keep,
   input  logic                   i_last,
   output logic                   o_emit_c,
   output blk_t                   o_blk_c
);

   logic [BLK_W-1:0]      r_data;
   logic [BLK_KEEP_W-1:0] r_keep;
   logic [1:0]            r_idx;

   logic [WORD_W-1:0]     w_mask;
   logic [BLK_W-1:0]      w_data;
   logic [BLK_KEEP_W-1:0] w_keep;

   // Merge the masked word into the current block at its word index
   always_comb begin
      w_mask = '0;
      for (int j = 0; j < 4; j++) begin
         w_mask[8*j +: 8] = {8{i_keep[j]}};
      end
      w_data   = r_data | (BLK_W'(i_data & w_mask) << {r_idx, 5'b0});
      w_keep   = r_keep | (BLK_KEEP_W'(i_keep) << {r_idx, 2'b0});
      o_emit_c = i_acc && ((r_idx == 2'd3) || (i_last && (w_keep != '0)));
      o_blk_c  = '{data: w_data, keep: w_keep};
   end

   // A segment end always restarts packing, even when nothing was emitted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_keep <= '0;
         r_idx  <= '0;
      end else if (i_clear || (i_acc && (o_emit_c || i_last))) begin
         r_data <= '0;
         r_keep <= '0;
         r_idx  <= '0;
      end else if (i_acc) begin
         r_data <= w_data;
         r_keep <= w_keep;
         r_idx  <= r_idx + 2'd1;
      end
   end

endmodule

// File: rtl/poly1305_block_framer.sv
// Packs an AAD+payload word stream into Poly1305 blocks and issues the
// RFC 8439 length block.
// Config macro: POLY1305_FRAMER_ZERO_PAD_EN forces aad_keep/pld_keep to all ones.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   start                           : begin a message (IDLE/DONE/ERR only)
//   in_valid/in_ready/in_data/in_keep/in_last : 32-bit word input
//   aad_valid/aad_data/aad_keep/aad_ready     : AAD block output
//   pld_valid/pld_data/pld_keep/pld_ready     : payload block output
//   len_valid/len_block/len_ready             : length block output
//   busy, done, err                 : status
module poly1305_block_framer
   import chacha_aead_pkg::*;
#(
   parameter int unsigned CNT_W = 38
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_W-1:0]      in_data,
   input  logic [WORD_KEEP_W-1:0] in_keep,
   input  logic                   in_last,
   output logic                   aad_valid,
   output logic [BLK_W-1:0]       aad_data,
   output logic [BLK_KEEP_W-1:0]  aad_keep,
   input  logic                   aad_ready,
   output logic                   pld_valid,
   output logic [BLK_W-1:0]       pld_data,
   output logic [BLK_KEEP_W-1:0]  pld_keep,
   input  logic                   pld_ready,
   output logic                   len_valid,
   output logic [BLK_W-1:0]       len_block,
   input  logic                   len_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   framer_state_t     r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_aad_cnt, r_pld_cnt;
   logic              r_blk_valid, r_blk_last;
   blk_t              r_blk;
   logic              r_len_valid;
   logic [BLK_W-1:0]  r_len_block;

   logic              w_start_ok, w_acc, w_err, w_word_ok, w_seg_close;
   logic              w_out_ready, w_blk_hs, w_pk_emit;
   logic [CNT_W:0]    w_sum;
   logic [BLK_W-1:0]  w_len_nxt;
   blk_t              w_pk_blk;

   // Word acceptance, error detection and counter arithmetic
   always_comb begin
      w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
      w_acc       = in_valid && in_ready;
      w_sum       = {1'b0, (r_state == ST_AAD) ? r_aad_cnt : r_pld_cnt}
                    + (CNT_W+1)'(keep_bytes(in_keep));
      w_err       = w_acc && (!keep_legal(in_keep) || ((in_keep != 4'hF) && !in_last) || w_sum[CNT_W]);
      w_word_ok   = w_acc && !w_err;
      w_out_ready = (r_state == ST_AAD) ? aad_ready : pld_ready;
      w_blk_hs    = r_blk_valid && w_out_ready;
      // Segment ends on an empty close with nothing pending, or when its last block is taken
      w_seg_close = (w_word_ok && in_last && !w_pk_emit) || (w_blk_hs && r_blk_last);
      w_len_nxt   = '0;
      w_len_nxt[LEN_AAD_LSB +: LEN_FIELD_W] = LEN_FIELD_W'(r_aad_cnt);
      w_len_nxt[LEN_PLD_LSB +: LEN_FIELD_W] = LEN_FIELD_W'(r_pld_cnt);
   end

   poly1305_word_packer u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_start_ok || w_err),
      .i_acc    (w_word_ok),
      .i_data   (in_data),
      .i_keep   (in_keep),
      .i_last   (in_last),
      .o_emit_c (w_pk_emit),
      .o_blk_c  (w_pk_blk)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: if (start) w_state_nxt = ST_AAD;
         ST_AAD: begin
            if (w_err)            w_state_nxt = ST_ERR;
            else if (w_seg_close) w_state_nxt = ST_PLD;
         end
         ST_PLD: begin
            if (w_err)            w_state_nxt = ST_ERR;
            else if (w_seg_close) w_state_nxt = ST_LEN;
         end
         ST_LEN: if (r_len_valid && len_ready) w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Counters, pending output block and length block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aad_cnt   <= '0;
         r_pld_cnt   <= '0;
         r_blk_valid <= 1'b0;
         r_blk_last  <= 1'b0;
         r_blk       <= '0;
         r_len_valid <= 1'b0;
         r_len_block <= '0;
      end else if (w_start_ok) begin
         r_aad_cnt   <= '0;
         r_pld_cnt   <= '0;
         r_blk_valid <= 1'b0;
         r_blk_last  <= 1'b0;
         r_len_valid <= 1'b0;
         r_len_block <= '0;
      end else begin
         if (w_err) begin
            r_blk_valid <= 1'b0;
         end else if (w_word_ok) begin
            if (r_state == ST_AAD) r_aad_cnt <= w_sum[CNT_W-1:0];
            else                   r_pld_cnt <= w_sum[CNT_W-1:0];
            if (w_pk_emit) begin
               r_blk_valid <= 1'b1;
               r_blk_last  <= in_last;
               r_blk.data  <= w_pk_blk.data;
`ifdef POLY1305_FRAMER_ZERO_PAD_EN
               r_blk.keep  <= '1;
`else
               r_blk.keep  <= w_pk_blk.keep;
`endif
            end
         end else if (w_blk_hs) begin
            r_blk_valid <= 1'b0;
         end
         if ((r_state == ST_PLD) && (w_state_nxt == ST_LEN)) begin
            r_len_valid <= 1'b1;
            r_len_block <= w_len_nxt;
         end else if (r_len_valid && len_ready) begin
            r_len_valid <= 1'b0;
         end
      end
   end

   // Output demux by segment; the pending block is only visible in its own state
   always_comb begin
      aad_valid = r_blk_valid && (r_state == ST_AAD);
      pld_valid = r_blk_valid && (r_state == ST_PLD);
      aad_data  = aad_valid ? r_blk.data : '0;
      aad_keep  = aad_valid ? r_blk.keep : '0;
      pld_data  = pld_valid ? r_blk.data : '0;
      pld_keep  = pld_valid ? r_blk.keep : '0;
      len_valid = r_len_valid;
      len_block = r_len_block;
      in_ready  = ((r_state == ST_AAD) || (r_state == ST_PLD)) && !r_blk_valid;
      busy      = (r_state == ST_AAD) || (r_state == ST_PLD) || (r_state == ST_LEN);
      done      = (r_state == ST_DONE);
      err       = (r_state == ST_ERR);
   end

endmodule

// File: tb/tb_poly1305_block_framer.sv
// Self-checking bench for poly1305_block_framer: table of message shapes plus
// random messages checked against a byte-level block model, and hand-written
// backpressure, error and reset sequences.
module tb_poly1305_block_framer;

   logic         clk, rst_n, start;
   logic         in_valid, in_ready, in_last;
   logic [31:0]  in_data;
   logic [3:0]   in_keep;
   logic         aad_valid, aad_ready, pld_valid, pld_ready, len_valid, len_ready;
   logic [127:0] aad_data, pld_data, len_block;
   logic [15:0]  aad_keep, pld_keep;
   logic         busy, done, err;

   poly1305_block_framer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_keep(in_keep), .in_last(in_last),
      .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
      .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
      .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   typedef struct {
      logic [127:0] d;
      logic [15:0]  k;
   } blk_t;

   typedef struct {
      int          an;
      int          pn;
      bit          ce;
      int          mode;
      int          na;
      int          np;
      logic [15:0] ak;
      logic [15:0] pk;
   } vec_t;

   int    errors = 0;
   int    checks = 0;
   word_t wq[$];
   blk_t  ea[$];
   blk_t  ep[$];
   int    n_aad, n_pld;
   logic [15:0] last_ak, last_pk;

   function automatic logic [15:0] padk(input logic [15:0] k);
`ifdef POLY1305_FRAMER_ZERO_PAD_EN
      return (k == 16'h0) ? 16'h0 : 16'hFFFF;
`else
      return k;
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Segment of n random bytes -> words on wq, expected 16-byte blocks on ea/ep
   task automatic build_seg(input int n, input bit ce, input bit is_aad);
      logic [7:0]   b[$];
      logic [31:0]  d;
      logic [127:0] bd;
      logic [15:0]  bk;
      int           nw, rem;
      bit           ce_eff;
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      ce_eff = ce && (n % 4 == 0);
      if (n == 0) begin
         wq.push_back('{d: $urandom, k: 4'h0, l: 1'b1});
      end else begin
         nw = (n + 3) / 4;
         for (int w = 0; w < nw; w++) begin
            rem = (n - 4*w > 4) ? 4 : n - 4*w;
            d = $urandom;
            for (int j = 0; j < rem; j++) d[8*j +: 8] = b[4*w + j];
            wq.push_back('{d: d, k: 4'((1 << rem) - 1), l: (w == nw - 1) && !ce_eff});
         end
         if (ce_eff) wq.push_back('{d: $urandom, k: 4'h0, l: 1'b1});
      end
      for (int c = 0; 16*c < n; c++) begin
         bd = '0;
         bk = '0;
         for (int i = 0; i < 16; i++) begin
            if (16*c + i < n) begin
               bd[8*i +: 8] = b[16*c + i];
               bk[i] = 1'b1;
            end
         end
         if (is_aad) ea.push_back('{d: bd, k: padk(bk)});
         else        ep.push_back('{d: bd, k: padk(bk)});
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // mode 0: all ready; 1: random readies; 2: pld_ready held low 10 cycles; 3: random + start while busy
   task automatic run_msg(input int an, input int pn, input bit ce, input int mode);
      int   wi, stall;
      bit   hs_in, hs_a, hs_p, hs_l, got_len, fin, hold_a, hold_p, hold_l;
      logic [127:0] prev_a, prev_p, prev_l;
      blk_t e;
      wq.delete(); ea.delete(); ep.delete();
      build_seg(an, ce, 1'b1);
      build_seg(pn, ce, 1'b0);
      n_aad = 0; n_pld = 0; last_ak = '0; last_pk = '0;
      wi = 0; stall = 0; got_len = 0; fin = 0;
      hold_a = 0; hold_p = 0; hold_l = 0;
      prev_a = '0; prev_p = '0; prev_l = '0;
      in_valid = 1'b0;
      pulse_start();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid = (wi < wq.size());
         if (wi < wq.size()) begin
            in_data = wq[wi].d; in_keep = wq[wi].k; in_last = wq[wi].l;
         end
         start = (mode == 3) && (cyc == 4) && (wi < wq.size());
         if (mode == 0) begin
            aad_ready = 1'b1; pld_ready = 1'b1; len_ready = 1'b1;
         end else if (mode == 2) begin
            aad_ready = 1'b1; pld_ready = (stall >= 10); len_ready = 1'b1;
         end else begin
            aad_ready = 1'($urandom_range(0, 1));
            pld_ready = 1'($urandom_range(0, 1));
            len_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (got_len && done) begin
            fin = 1;
            break;
         end
         hs_in = in_valid && in_ready;
         hs_a  = aad_valid && aad_ready;
         hs_p  = pld_valid && pld_ready;
         hs_l  = len_valid && len_ready;
         chk("one_valid", 128'((32'(aad_valid) + 32'(pld_valid) + 32'(len_valid)) > 1), 128'(0));
         chk("in_ready_vs_pending", 128'(in_ready && (aad_valid || pld_valid || len_valid)), 128'(0));
         if (hold_a) chk("aad_hold", {aad_valid, aad_data[126:0]}, {1'b1, prev_a[126:0]});
         if (hold_p) chk("pld_hold", {pld_valid, pld_data[126:0]}, {1'b1, prev_p[126:0]});
         if (hold_l) chk("len_hold", {len_valid, len_block[126:0]}, {1'b1, prev_l[126:0]});
         hold_a = aad_valid && !aad_ready; prev_a = aad_data;
         hold_p = pld_valid && !pld_ready; prev_p = pld_data;
         hold_l = len_valid && !len_ready; prev_l = len_block;
         if (mode == 2 && pld_valid && !pld_ready) stall++;
         if (hs_a) begin
            n_aad++; last_ak = aad_keep;
            if (ea.size() == 0) begin
               errors++; checks++;
               $display("FAIL aad_extra: got unexpected block %h", aad_data);
            end else begin
               e = ea.pop_front();
               chk("aad_data", aad_data, e.d);
               chk("aad_keep", 128'(aad_keep), 128'(e.k));
            end
         end
         if (hs_p) begin
            n_pld++; last_pk = pld_keep;
            if (ep.size() == 0) begin
               errors++; checks++;
               $display("FAIL pld_extra: got unexpected block %h", pld_data);
            end else begin
               e = ep.pop_front();
               chk("pld_data", pld_data, e.d);
               chk("pld_keep", 128'(pld_keep), 128'(e.k));
            end
         end
         if (hs_l) begin
            got_len = 1;
            chk("len_block", len_block, {64'(pn), 64'(an)});
         end
         @(posedge clk); #1;
         if (hs_in) wi++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      if (!fin) begin
         errors++; checks++;
         $display("FAIL msg_timeout: got words=%0d/%0d len=%0d expected completion", wi, wq.size(), got_len);
      end
      chk("aad_left", 128'(ea.size()), 128'(0));
      chk("pld_left", 128'(ep.size()), 128'(0));
      chk("done_end", {busy, done, err}, 128'(3'b010));
   endtask

   // Present one word and wait (bounded) for it to be accepted
   task automatic put_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         errors++; checks++;
         $display("FAIL put_word_timeout: got in_ready=0 expected 1 within 50 cycles");
      end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic check_err_state(input string name);
      @(negedge clk);
      chk(name, {err, busy, in_ready}, 128'(3'b100));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk({name, "_quiet"}, {aad_valid, pld_valid, len_valid, in_ready, err}, 128'(5'b00001));
      end
   endtask

   task automatic check_reset_outs(input string name);
      chk({name, "_ctl"}, {aad_valid, pld_valid, len_valid, in_ready, busy, done, err}, 128'(0));
      chk({name, "_aad"}, aad_data, 128'(0));
      chk({name, "_pld"}, pld_data, 128'(0));
      chk({name, "_len"}, len_block, 128'(0));
      chk({name, "_keep"}, {aad_keep, pld_keep}, 128'(0));
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{12, 20, 1'b0, 0, 1, 2, 16'h0FFF, 16'h000F};
      tbl[1] = '{ 0, 16, 1'b0, 0, 0, 1, 16'h0000, 16'hFFFF};
      tbl[2] = '{16,  0, 1'b1, 1, 1, 0, 16'hFFFF, 16'h0000};
      tbl[3] = '{ 0,  0, 1'b0, 1, 0, 0, 16'h0000, 16'h0000};
      tbl[4] = '{33,  7, 1'b0, 1, 3, 1, 16'h0001, 16'h007F};
      tbl[5] = '{ 5, 64, 1'b1, 2, 1, 4, 16'h001F, 16'hFFFF};
      tbl[6] = '{40, 18, 1'b0, 3, 3, 2, 16'h00FF, 16'h0003};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
      aad_ready = 1'b0; pld_ready = 1'b0; len_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_msg(tbl[i].an, tbl[i].pn, tbl[i].ce, tbl[i].mode);
         chk("tbl_n_aad", 128'(n_aad), 128'(tbl[i].na));
         chk("tbl_n_pld", 128'(n_pld), 128'(tbl[i].np));
         if (tbl[i].na > 0) chk("tbl_aad_last_keep", 128'(last_ak), 128'(padk(tbl[i].ak)));
         if (tbl[i].np > 0) chk("tbl_pld_last_keep", 128'(last_pk), 128'(padk(tbl[i].pk)));
      end

      for (int i = 0; i < 12; i++) begin
         run_msg(int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 1 : 3);
      end

      // Illegal keep pattern
      pulse_start();
      put_word($urandom, 4'h5, 1'b0);
      check_err_state("err_keep5");
      // Partial keep without last, after a good word
      pulse_start();
      put_word($urandom, 4'hF, 1'b0);
      put_word($urandom, 4'h3, 1'b0);
      check_err_state("err_keep3_nolast");
      // Empty word without last, in the payload segment
      pulse_start();
      put_word($urandom, 4'h0, 1'b1);
      put_word($urandom, 4'h0, 1'b0);
      check_err_state("err_keep0_nolast");
      // Clean restart from ERR
      run_msg(12, 20, 1'b0, 0);
      chk("restart_n_pld", 128'(n_pld), 128'(2));

      // Reset while a payload block is pending
      aad_ready = 1'b1; pld_ready = 1'b0; len_ready = 1'b1;
      pulse_start();
      put_word($urandom, 4'h0, 1'b1);
      for (int w = 0; w < 4; w++) put_word($urandom, 4'hF, w == 3);
      @(negedge clk);
      chk("rst_pld_pending", 128'(pld_valid), 128'(1));
      rst_n = 1'b0;
      #1;
      check_reset_outs("async_reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset_outs("after_reset");
      run_msg(20, 3, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
